// File: rtl/gc_dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gc_dram_pkg
//  Brief    : Shared sizes, types and age helper for the refresh-less
//             gain-cell DRAM controller.
//  Revision : 1.0 - initial release
// ============================================================================
package gc_dram_pkg;

  localparam int ADDR_W         = 10;
  localparam int DATA_W         = 64;
  localparam int DEPTH          = 1 << ADDR_W;
  localparam int DEF_DRT_CYCLES = 50;
  // Must satisfy DRT_CYCLES + DEPTH < 2**(TS_W-1) so that the scanner clears
  // every expired word long before its timestamp can alias after a wrap.
  localparam int TS_W           = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [TS_W-1:0]   ts_t;

  // Cycles elapsed since a word was stamped, modulo the counter range.
  function automatic ts_t ts_age(input ts_t now, input ts_t stamp);
    return ts_t'(now - stamp);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gc_retention_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : gc_retention_tracker
//  Brief    : Per-word valid bits, write timestamps, free-running timestamp
//             counter and background expiry scanner. Reports whether the
//             word at raddr still holds its data.
//  Revision : 1.0 - initial release
// ============================================================================
module gc_retention_tracker
  import gc_dram_pkg::*;
#(
  parameter int DRT_CYCLES = DEF_DRT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  output logic              word_alive
);

  localparam ts_t DRT_LIMIT = ts_t'(DRT_CYCLES);

  // Timestamp storage array; contents are meaningless until the valid bit is set.
  ts_t              ts_ram [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  ts_t              counter_q, counter_d;
  addr_t            scan_ptr_q, scan_ptr_d;
  ts_t              read_age, scan_age;

  assign read_age   = ts_age(counter_q, ts_ram[raddr]);
  assign scan_age   = ts_age(counter_q, ts_ram[scan_ptr_q]);
  assign word_alive = valid_q[raddr] && (read_age <= DRT_LIMIT);

  // Stamp each written word with the current counter value.
  always_ff @(posedge clk) begin
    if (we) ts_ram[waddr] <= counter_q;
  end

  // Next-state: counter/scanner advance; scanner expiry, then write sets valid (write wins).
  always_comb begin
    valid_d    = valid_q;
    counter_d  = counter_q + ts_t'(1);
    scan_ptr_d = scan_ptr_q + addr_t'(1);
    if (valid_q[scan_ptr_q] && (scan_age > DRT_LIMIT)) valid_d[scan_ptr_q] = 1'b0;
    if (we) valid_d[waddr] = 1'b1;
  end

  // Tracker state registers; array contents are deliberately left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      counter_q  <= '0;
      scan_ptr_q <= '0;
    end else begin
      valid_q    <= valid_d;
      counter_q  <= counter_d;
      scan_ptr_q <= scan_ptr_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/gc_dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : gc_dram_ctrl
//  Brief    : Refresh-less gain-cell DRAM controller top: data array,
//             write-first collision bypass and registered read data. Words
//             past their retention time read back as zero.
//  Revision : 1.0 - initial release
// ============================================================================
module gc_dram_ctrl
  import gc_dram_pkg::*;
#(
  parameter int DRT_CYCLES = DEF_DRT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] rd
);

  // Data storage array; never reset, liveness comes from the tracker.
  data_t mem [DEPTH];
  data_t rd_q, rd_d;
  logic  word_alive;

  gc_retention_tracker #(
    .DRT_CYCLES (DRT_CYCLES)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .raddr      (raddr),
    .word_alive (word_alive)
  );

  // Array write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= in;
  end

  // Read data select: same-address write bypasses, dead words read as zero, idle holds.
  always_comb begin
    rd_d = rd_q;
    if (re) begin
      if (we && (waddr == raddr)) rd_d = in;
      else if (word_alive)        rd_d = mem[raddr];
      else                        rd_d = '0;
    end
  end

  // Read data register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rd = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_gc_dram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gc_dram_ctrl
//  Brief    : Directed self-checking bench for gc_dram_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gc_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [9:0]  waddr = '0;
  logic [9:0]  raddr = '0;
  logic [63:0] in = '0;
  logic [63:0] rd;

  int total = 0;
  int bad   = 0;

  gc_dram_ctrl #(.DRT_CYCLES(50)) dut (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .waddr (waddr),
    .raddr (raddr),
    .in    (in),
    .rd    (rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, leave 1 ns for outputs to settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    we = 1'b0;
    re = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_write(input logic [9:0] a, input logic [63:0] d);
    we = 1'b1; re = 1'b0; waddr = a; in = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a);
    we = 1'b0; re = 1'b1; raddr = a;
    cyc();
    re = 1'b0;
  endtask

  logic [63:0] d;
  logic [9:0]  a;
  logic        w;

  initial begin
    // Reset state
    #2;
    chk("reset_rd", rd, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Unwritten address held for 6 cycles
    re = 1'b1; raddr = 10'h3FF;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("unwritten_3ff", rd, 64'h0);
    end
    re = 1'b0;

    // Random write then read-back; unwritten addresses must read zero
    for (int i = 0; i < 32; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {1'b1, 4'($urandom_range(0, 14)), 5'(i)};
      d = {$urandom, $urandom};
      we = w; re = 1'b0; waddr = a; in = d;
      cyc();
      do_read(a);
      chk("regular_rdback", rd, w ? d : 64'h0);
    end

    // Collision: same-address write-first bypass, then plain read
    we = 1'b1; re = 1'b1; waddr = 10'h2A; raddr = 10'h2A; in = 64'hA5A5_A5A5_A5A5_A5A5;
    cyc();
    chk("collide_bypass", rd, 64'hA5A5_A5A5_A5A5_A5A5);
    do_read(10'h2A);
    chk("collide_after", rd, 64'hA5A5_A5A5_A5A5_A5A5);
    // Different addresses in the same cycle
    we = 1'b1; re = 1'b1; waddr = 10'h30; raddr = 10'h2A; in = 64'h1111_2222_3333_4444;
    cyc();
    chk("dual_read_other", rd, 64'hA5A5_A5A5_A5A5_A5A5);
    do_read(10'h30);
    chk("dual_write_other", rd, 64'h1111_2222_3333_4444);

    // Retention expiry: write at edge t, read at t+1, t+50, t+51
    do_write(10'h155, 64'hDEAD_BEEF_0123_4567);
    do_read(10'h155);
    chk("drt_age1", rd, 64'hDEAD_BEEF_0123_4567);
    idle(48);
    chk("hold_re0", rd, 64'hDEAD_BEEF_0123_4567);
    do_read(10'h155);
    chk("drt_age50", rd, 64'hDEAD_BEEF_0123_4567);
    do_read(10'h155);
    chk("drt_age51", rd, 64'h0);
    // Overwrite after expiry restores the word
    do_write(10'h155, 64'h0BAD_F00D_CAFE_0001);
    do_read(10'h155);
    chk("rewrite_expired", rd, 64'h0BAD_F00D_CAFE_0001);

    // Rewrite refresh: age 80 from first write, 40 from rewrite
    do_write(10'd5, 64'h5555_0000_0000_0001);
    idle(39);
    do_write(10'd5, 64'h5555_0000_0000_0002);
    idle(39);
    do_read(10'd5);
    chk("refresh_rewrite", rd, 64'h5555_0000_0000_0002);

    // Async reset mid-cycle clears rd at once and forgets stored words
    idle(2);
    rst = 1'b1;
    #1;
    chk("async_rst_rd", rd, 64'h0);
    #2;
    rst = 1'b0;
    cyc();
    do_read(10'd5);
    chk("post_rst_word", rd, 64'h0);
    do_read(10'h30);
    chk("post_rst_word2", rd, 64'h0);

    // Wrap aliasing: read at age 65536+10, raw timestamp age looks like 10
    do_write(10'd7, 64'h7777_7777_7777_7777);
    idle(65545);
    do_read(10'd7);
    chk("wrap_alias", rd, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
